// File: rtl/register_operand_collector_pkg.sv
// Shared types for the register operand collector: FSM encoding and tag sizing.
package register_opc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        DONE    = 2'd3
    } opc_state_e;

    // A single-operand configuration still needs a 1-bit tag on the bank port.
    function automatic int unsigned opc_tag_width(input int unsigned num_operands);
        return (num_operands > 1) ? $clog2(num_operands) : 1;
    endfunction

endpackage

// File: rtl/register_operand_collector_lzc.sv
// Leading/trailing zero counter with the common_cells lzc interface.
// MODE=0 counts trailing zeros, i.e. returns the index of the lowest set bit.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE == 1'b0) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/register_operand_collector.sv
// Collects up to NumOperands source operands for one instruction from a single
// register file bank read port and hands the complete set downstream.
module register_operand_collector
    import register_opc_pkg::*;
#(
    parameter int unsigned WarpWidth     = 8,
    parameter int unsigned RegisterWidth = 32,
    parameter int unsigned NumRegisters  = 32,
    parameter int unsigned NumOperands   = 3,
    parameter int unsigned InstrIdWidth  = 4
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             instr_valid_i,
    output logic                                             instr_ready_o,
    input  logic [InstrIdWidth-1:0]                          instr_id_i,
    input  logic [NumOperands-1:0]                           instr_used_i,
    input  logic [NumOperands*$clog2(NumRegisters)-1:0]      instr_addr_i,
    output logic                                             bank_read_valid_o,
    input  logic                                             bank_read_ready_i,
    output logic [$clog2(NumRegisters)-1:0]                  bank_read_addr_o,
    output logic [opc_tag_width(NumOperands)-1:0]            bank_read_tag_o,
    input  logic                                             bank_resp_valid_i,
    input  logic [opc_tag_width(NumOperands)-1:0]            bank_resp_tag_i,
    input  logic [RegisterWidth*WarpWidth-1:0]               bank_resp_data_i,
    output logic                                             opc_valid_o,
    input  logic                                             opc_ready_i,
    output logic [InstrIdWidth-1:0]                          opc_id_o,
    output logic [NumOperands*RegisterWidth*WarpWidth-1:0]   opc_data_o
);

    localparam int unsigned AddrWidth = $clog2(NumRegisters);
    localparam int unsigned TagWidth  = opc_tag_width(NumOperands);

    typedef logic [AddrWidth-1:0]                      addr_t;
    typedef logic [TagWidth-1:0]                       tag_t;
    typedef logic [RegisterWidth-1:0][WarpWidth-1:0]   warp_data_t;

    if (NumOperands < 1) begin : g_num_operands_check
        $error("register_operand_collector: NumOperands must be at least 1");
    end

    opc_state_e                    r_state;
    opc_state_e                    w_state_next;
    logic [InstrIdWidth-1:0]       r_id;
    logic [NumOperands-1:0]        r_used;
    logic [NumOperands-1:0]        r_pending;
    logic [NumOperands-1:0]        r_received;
    addr_t [NumOperands-1:0]       r_addr;
    warp_data_t [NumOperands-1:0]  r_data;

    tag_t                          w_lowest;
    logic                          w_pend_empty;
    logic [NumOperands-1:0]        w_lowest_oh;
    logic [NumOperands-1:0]        w_resp_oh;
    logic [NumOperands-1:0]        w_outstanding;
    logic [NumOperands-1:0]        w_resp_set;
    logic                          w_instr_fire;
    logic                          w_req_fire;
    logic                          w_resp_active;
    logic                          w_resp_ok;
    logic                          w_resp_dropped;
    addr_t                         w_read_addr;
    warp_data_t                    w_resp_data;

    lzc #(
        .WIDTH     (NumOperands),
        .MODE      (1'b0),
        .CNT_WIDTH (TagWidth)
    ) i_lzc (
        .in_i    (r_pending),
        .cnt_o   (w_lowest),
        .empty_o (w_pend_empty)
    );

    assign w_lowest_oh   = NumOperands'(1) << w_lowest;
    assign w_resp_oh     = NumOperands'(1) << bank_resp_tag_i;
    assign w_resp_data   = bank_resp_data_i;
    assign w_read_addr   = r_addr[w_lowest];

    // A tag is outstanding once its request has been accepted and until its data lands.
    assign w_outstanding  = r_used & ~r_pending & ~r_received;
    assign w_resp_active  = (r_state == REQUEST) || (r_state == WAIT);
    assign w_resp_ok      = bank_resp_valid_i && w_resp_active && (|(w_resp_oh & w_outstanding));
    assign w_resp_dropped = bank_resp_valid_i && !w_resp_ok;
    assign w_resp_set     = w_resp_ok ? w_resp_oh : '0;

    assign instr_ready_o     = (r_state == IDLE);
    assign bank_read_valid_o = (r_state == REQUEST) && !w_pend_empty;
    assign bank_read_addr_o  = bank_read_valid_o ? w_read_addr : '0;
    assign bank_read_tag_o   = bank_read_valid_o ? w_lowest : '0;
    assign opc_valid_o       = (r_state == DONE);
    assign opc_id_o          = r_id;
    assign opc_data_o        = r_data;

    assign w_instr_fire = instr_valid_i && instr_ready_o;
    assign w_req_fire   = bank_read_valid_o && bank_read_ready_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (instr_valid_i) w_state_next = (|instr_used_i) ? REQUEST : DONE;
            end
            REQUEST: begin
                if (w_req_fire && ((r_pending & ~w_lowest_oh) == '0)) w_state_next = WAIT;
            end
            WAIT: begin
                if ((r_received | w_resp_set) == r_used) w_state_next = DONE;
            end
            DONE: begin
                if (opc_ready_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id       <= '0;
            r_used     <= '0;
            r_pending  <= '0;
            r_received <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else if (w_instr_fire) begin
            r_id       <= instr_id_i;
            r_used     <= instr_used_i;
            r_pending  <= instr_used_i;
            r_received <= '0;
            r_addr     <= instr_addr_i;
            r_data     <= '0;
        end else begin
            if (w_req_fire) r_pending <= r_pending & ~w_lowest_oh;
            r_received <= r_received | w_resp_set;
            for (int i = 0; i < int'(NumOperands); i++) begin
                if (w_resp_set[i]) r_data[i] <= w_resp_data;
            end
        end
    end

    // Covers both responses in IDLE/DONE and responses for tags never requested.
    resp_dropped_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_resp_dropped)
        else $warning("register_operand_collector: bank response dropped (tag %0d)", bank_resp_tag_i);

endmodule
